// File: rtl/amo_queue.sv
// Atomic memory operation queue: buffers AMOs, tracks commit and issues the oldest committed one.
// Optional AMO_QUEUE_STATS_EN adds a saturating counter of issued AMOs on amo_cnt_o.

package riscv;
    localparam int PLEN = 56;
    localparam int XLEN = 64;
endpackage

package ariane_pkg;
    typedef enum logic [3:0] {
        AMO_NONE, AMO_LR, AMO_SC, AMO_SWAP, AMO_ADD, AMO_AND, AMO_OR,
        AMO_XOR, AMO_MAX, AMO_MAXU, AMO_MIN, AMO_MINU, AMO_CAS1, AMO_CAS2
    } amo_t;

    typedef struct packed {
        logic        req;
        amo_t        amo_op;
        logic [1:0]  size;
        logic [63:0] operand_a;
        logic [63:0] operand_b;
    } amo_req_t;

    typedef struct packed {
        logic        ack;
        logic [63:0] result;
    } amo_resp_t;
endpackage

module amo_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  ariane_pkg::amo_t         amo_op_i,
    input  logic [riscv::PLEN-1:0]   paddr_i,
    input  logic [riscv::XLEN-1:0]   data_i,
    input  logic [1:0]               data_size_i,
    input  logic                     amo_commit_i,
    input  logic                     no_st_pending_i,
    output ariane_pkg::amo_req_t     amo_req_o,
    input  ariane_pkg::amo_resp_t    amo_resp_i,
    output logic [$clog2(DEPTH):0]   usage_o,
    output logic [$clog2(DEPTH):0]   committed_o,
    output logic [CNT_W-1:0]         amo_cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        ariane_pkg::amo_t        op;
        logic [riscv::PLEN-1:0]  paddr;
        logic [riscv::XLEN-1:0]  data;
        logic [1:0]              size;
    } entry_t;

    typedef enum logic {IDLE, ISSUE} state_t;

    entry_t mem [DEPTH];
    entry_t head_entry;

    state_t         state_reg, state_next;
    logic [PW-1:0]  head_reg, head_next;
    logic [PW-1:0]  tail_reg, tail_next;
    logic [PW-1:0]  commit_reg, commit_next;
    logic [CW-1:0]  usage_reg, usage_next;
    logic [CW-1:0]  committed_reg, committed_next;

    logic do_push, do_commit, do_pop, start_issue;
    logic unused_resp;

    assign unused_resp = ^amo_resp_i.result;

    always_comb begin
        ready_o     = usage_reg < CW'(DEPTH);
        do_push     = valid_i & ready_o & ~flush_i;
        do_commit   = amo_commit_i & (committed_reg < usage_reg);
        do_pop      = (state_reg == ISSUE) & amo_resp_i.ack;
        start_issue = (state_reg == IDLE) & (committed_reg != '0) & no_st_pending_i;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_issue) state_next = ISSUE;
            ISSUE:   if (amo_resp_i.ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Commit is applied before flush, so the entry committed this cycle survives.
    always_comb begin
        head_next      = head_reg + PW'(do_pop);
        commit_next    = commit_reg + PW'(do_commit);
        committed_next = committed_reg + CW'(do_commit) - CW'(do_pop);
        if (flush_i) begin
            tail_next  = commit_next;
            usage_next = committed_next;
        end else begin
            tail_next  = tail_reg + PW'(do_push);
            usage_next = usage_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            state_reg     <= IDLE;
            head_reg      <= '0;
            tail_reg      <= '0;
            commit_reg    <= '0;
            usage_reg     <= '0;
            committed_reg <= '0;
        end else begin
            state_reg     <= state_next;
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            commit_reg    <= commit_next;
            usage_reg     <= usage_next;
            committed_reg <= committed_next;
        end
    end

    // Pushes only land in free slots, so the in-flight head is never overwritten.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[tail_reg] <= '{op: amo_op_i, paddr: paddr_i, data: data_i, size: data_size_i};
        end
    end

    assign head_entry = mem[head_reg];

    always_comb begin
        amo_req_o.req       = (state_reg == ISSUE);
        amo_req_o.amo_op    = head_entry.op;
        amo_req_o.size      = head_entry.size;
        amo_req_o.operand_a = 64'(head_entry.paddr);
        amo_req_o.operand_b = 64'(head_entry.data);
    end

    assign usage_o     = usage_reg;
    assign committed_o = committed_reg;

`ifdef AMO_QUEUE_STATS_EN
    logic [CNT_W-1:0] amo_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            amo_cnt_reg <= '0;
        end else if (start_issue && !clr_i && amo_cnt_reg != '1) begin
            amo_cnt_reg <= amo_cnt_reg + CNT_W'(1);
        end
    end

    assign amo_cnt_o = amo_cnt_reg;
`else
    assign amo_cnt_o = '0;
`endif

endmodule

// File: tb/tb_amo_queue.sv
// Directed bench for amo_queue: per-cycle vector table plus a wrap-around issue/ack sequence.
module tb_amo_queue;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic                    clk_i = 1'b0;
    logic                    rst_ni = 1'b0;
    logic                    clr_i = 1'b0;
    logic                    flush_i = 1'b0;
    logic                    valid_i = 1'b0;
    logic                    ready_o;
    ariane_pkg::amo_t        amo_op_i = ariane_pkg::AMO_NONE;
    logic [riscv::PLEN-1:0]  paddr_i = '0;
    logic [riscv::XLEN-1:0]  data_i = '0;
    logic [1:0]              data_size_i = '0;
    logic                    amo_commit_i = 1'b0;
    logic                    no_st_pending_i = 1'b0;
    ariane_pkg::amo_req_t    amo_req_o;
    ariane_pkg::amo_resp_t   amo_resp_i;
    logic [$clog2(DEPTH):0]  usage_o;
    logic [$clog2(DEPTH):0]  committed_o;
    logic [CNT_W-1:0]        amo_cnt_o;
    logic                    ack = 1'b0;

    assign amo_resp_i = '{ack: ack, result: 64'h0};

    always #5 clk_i = ~clk_i;

    amo_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .amo_op_i(amo_op_i),
        .paddr_i(paddr_i), .data_i(data_i), .data_size_i(data_size_i),
        .amo_commit_i(amo_commit_i), .no_st_pending_i(no_st_pending_i),
        .amo_req_o(amo_req_o), .amo_resp_i(amo_resp_i),
        .usage_o(usage_o), .committed_o(committed_o), .amo_cnt_o(amo_cnt_o)
    );

    typedef struct {
        logic       rst_n, clr, v;
        logic [7:0] a;
        logic       cm, f, n, k;
        int         eu, ec;
        logic       er, eq;
        logic [7:0] ea;
        int         ecnt;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic ariane_pkg::amo_t op_of(input logic [7:0] a);
        return ariane_pkg::amo_t'(4'(a[1:0]) + 4'd3);
    endfunction

    function automatic void add(input logic r, c, v, input logic [7:0] a,
                                input logic cm, f, n, k, input int eu, ec,
                                input logic er, eq, input logic [7:0] ea, input int ecnt);
        vec_t t;
        t = '{r, c, v, a, cm, f, n, k, eu, ec, er, eq, ea, ecnt};
        vecs.push_back(t);
    endfunction

    task automatic apply(input logic r, c, v, input logic [7:0] a, input logic cm, f, n, k);
        @(negedge clk_i);
        rst_ni          = r;
        clr_i           = c;
        valid_i         = v;
        paddr_i         = riscv::PLEN'(a);
        data_i          = 64'hD000 | 64'(a);
        data_size_i     = a[1:0];
        amo_op_i        = op_of(a);
        amo_commit_i    = cm;
        flush_i         = f;
        no_st_pending_i = n;
        ack             = k;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_req(input string tag, input logic [7:0] ea);
        ariane_pkg::amo_t eop;
        eop = op_of(ea);
        chk({tag, "_opa"}, amo_req_o.operand_a, 64'(ea));
        chk({tag, "_opb"}, amo_req_o.operand_b, 64'hD000 | 64'(ea));
        chk({tag, "_op"}, 64'(amo_req_o.amo_op), 64'(eop));
        chk({tag, "_size"}, 64'(amo_req_o.size), 64'(ea[1:0]));
    endtask

    task automatic issue_ack(input logic [7:0] ea);
        int n = 0;
        while (!amo_req_o.req && n < 8) begin
            apply(1, 0, 0, 8'h0, 0, 0, 1, 0);
            n++;
        end
        chk("wrap_issue_wait", 64'(amo_req_o.req), 64'd1);
        if (amo_req_o.req) check_req("wrap", ea);
        $display("wrap issue addr=%0h after %0d cycles", amo_req_o.operand_a, n);
        apply(1, 0, 0, 8'h0, 0, 0, 0, 1);
        chk("wrap_req_drop", 64'(amo_req_o.req), 64'd0);
    endtask

    initial begin
        //  rst clr v  addr  cm f  n  k   eu ec er eq ea   cnt
        add(0, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 8'h00, 0);
        // fill to full, fifth push dropped
        add(1, 0, 1, 8'h10, 0, 0, 0, 0,  1, 0, 1, 0, 8'h00, 0);
        add(1, 0, 1, 8'h20, 0, 0, 0, 0,  2, 0, 1, 0, 8'h00, 0);
        add(1, 0, 1, 8'h30, 0, 0, 0, 0,  3, 0, 1, 0, 8'h00, 0);
        add(1, 0, 1, 8'h40, 0, 0, 0, 0,  4, 0, 0, 0, 8'h00, 0);
        add(1, 0, 1, 8'h50, 0, 0, 0, 0,  4, 0, 0, 0, 8'h00, 0);
        add(1, 0, 0, 8'h00, 0, 0, 1, 0,  4, 0, 0, 0, 8'h00, 0);
        add(1, 1, 0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 8'h00, 0);
        // commit, issue, ack; second issue after exactly one idle cycle
        add(1, 0, 1, 8'h11, 0, 0, 0, 0,  1, 0, 1, 0, 8'h00, 0);
        add(1, 0, 1, 8'h22, 0, 0, 0, 0,  2, 0, 1, 0, 8'h00, 0);
        add(1, 0, 0, 8'h00, 1, 0, 1, 0,  2, 1, 1, 0, 8'h00, 0);
        add(1, 0, 0, 8'h00, 0, 0, 1, 0,  2, 1, 1, 1, 8'h11, 1);
        add(1, 0, 0, 8'h00, 1, 0, 0, 0,  2, 2, 1, 1, 8'h11, 1);
        add(1, 0, 0, 8'h00, 0, 0, 0, 0,  2, 2, 1, 1, 8'h11, 1);
        add(1, 0, 0, 8'h00, 0, 0, 1, 1,  1, 1, 1, 0, 8'h00, 1);
        add(1, 0, 0, 8'h00, 0, 0, 1, 0,  1, 1, 1, 1, 8'h22, 2);
        add(1, 0, 0, 8'h00, 0, 0, 0, 1,  0, 0, 1, 0, 8'h00, 2);
        add(1, 0, 0, 8'h00, 0, 0, 0, 1,  0, 0, 1, 0, 8'h00, 2);
        // commit coinciding with flush
        add(1, 0, 1, 8'h31, 0, 0, 0, 0,  1, 0, 1, 0, 8'h00, 2);
        add(1, 0, 1, 8'h32, 0, 0, 0, 0,  2, 0, 1, 0, 8'h00, 2);
        add(1, 0, 1, 8'h33, 0, 0, 0, 0,  3, 0, 1, 0, 8'h00, 2);
        add(1, 0, 0, 8'h00, 1, 0, 0, 0,  3, 1, 1, 0, 8'h00, 2);
        add(1, 0, 0, 8'h00, 1, 1, 0, 0,  2, 2, 1, 0, 8'h00, 2);
        add(1, 0, 1, 8'h34, 0, 0, 0, 0,  3, 2, 1, 0, 8'h00, 2);
        // flush and store-pending drop during ISSUE
        add(1, 0, 0, 8'h00, 0, 0, 1, 0,  3, 2, 1, 1, 8'h31, 3);
        add(1, 0, 0, 8'h00, 0, 1, 0, 0,  2, 2, 1, 1, 8'h31, 3);
        add(1, 0, 0, 8'h00, 0, 0, 0, 0,  2, 2, 1, 1, 8'h31, 3);
        add(1, 0, 0, 8'h00, 0, 0, 0, 1,  1, 1, 1, 0, 8'h00, 3);
        add(1, 0, 0, 8'h00, 0, 0, 1, 0,  1, 1, 1, 1, 8'h32, 3);
        add(1, 0, 0, 8'h00, 0, 0, 0, 1,  0, 0, 1, 0, 8'h00, 3);
        // reset mid-request, late ack ignored
        add(1, 0, 1, 8'h41, 0, 0, 0, 0,  1, 0, 1, 0, 8'h00, 3);
        add(1, 0, 1, 8'h42, 1, 0, 0, 0,  2, 1, 1, 0, 8'h00, 3);
        add(1, 0, 1, 8'h43, 0, 0, 1, 0,  3, 1, 1, 1, 8'h41, 3);
        add(0, 0, 0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 8'h00, 0);
        add(1, 0, 0, 8'h00, 0, 0, 0, 1,  0, 0, 1, 0, 8'h00, 0);
        // clear mid-request keeps the statistics count
        add(1, 0, 1, 8'h51, 0, 0, 0, 0,  1, 0, 1, 0, 8'h00, 0);
        add(1, 0, 0, 8'h00, 1, 0, 0, 0,  1, 1, 1, 0, 8'h00, 0);
        add(1, 0, 0, 8'h00, 0, 0, 1, 0,  1, 1, 1, 1, 8'h51, 1);
        add(1, 1, 0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 8'h00, 1);

        foreach (vecs[i]) begin
            vec_t t;
            int ecnt;
            string tag;
            t = vecs[i];
`ifdef AMO_QUEUE_STATS_EN
            ecnt = t.ecnt;
`else
            ecnt = 0;
`endif
            tag = $sformatf("row%0d", i);
            apply(t.rst_n, t.clr, t.v, t.a, t.cm, t.f, t.n, t.k);
            $display("%s: usage=%0d committed=%0d ready=%0b req=%0b addr=%0h cnt=%0d",
                     tag, usage_o, committed_o, ready_o, amo_req_o.req,
                     amo_req_o.operand_a, amo_cnt_o);
            chk({tag, "_usage"}, 64'(usage_o), 64'(t.eu));
            chk({tag, "_committed"}, 64'(committed_o), 64'(t.ec));
            chk({tag, "_ready"}, 64'(ready_o), 64'(t.er));
            chk({tag, "_req"}, 64'(amo_req_o.req), 64'(t.eq));
            chk({tag, "_cnt"}, 64'(amo_cnt_o), 64'(ecnt));
            if (t.eq) check_req(tag, t.ea);
        end

        // wrap-around: offset pointers by two, then fill and drain in order
        apply(1, 0, 1, 8'h60, 0, 0, 0, 0);
        apply(1, 0, 1, 8'h61, 1, 0, 0, 0);
        apply(1, 0, 0, 8'h00, 1, 0, 0, 0);
        issue_ack(8'h60);
        issue_ack(8'h61);
        for (int i = 0; i < 4; i++) apply(1, 0, 1, 8'(8'h70 + i), 0, 0, 0, 0);
        chk("wrap_full_ready", 64'(ready_o), 64'd0);
        chk("wrap_full_usage", 64'(usage_o), 64'd4);
        for (int i = 0; i < 4; i++) apply(1, 0, 0, 8'h00, 1, 0, 0, 0);
        chk("wrap_committed", 64'(committed_o), 64'd4);
        for (int i = 0; i < 4; i++) issue_ack(8'(8'h70 + i));
        chk("wrap_empty_usage", 64'(usage_o), 64'd0);
        chk("wrap_empty_committed", 64'(committed_o), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/amo_queue.md
AMO_QUEUE -- requirements
Module: amo_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of AMO entries held (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of the issued-AMO statistics counter.
REQ-003 SHALL have one clock, clk_i; reset is synchronous and active-low, rst_ni.
REQ-004 SHALL have ports as follows (clock and reset first):
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- clr_i  in  1  synchronous clear, active high
- flush_i  in  1  pipeline flush
- valid_i  in  1  push AMO
- ready_o  out  1  queue not full
- amo_op_i  in  ariane_pkg::amo_t  AMO operation
- paddr_i  in  riscv::PLEN  physical address
- data_i  in  riscv::XLEN  operand data
- data_size_i  in  2  access size
- amo_commit_i  in  1  commit stage retires the oldest uncommitted AMO
- no_st_pending_i  in  1  store buffer drained
- amo_req_o  out  ariane_pkg::amo_req_t  request to cache
- amo_resp_i  in  ariane_pkg::amo_resp_t  response from cache
- usage_o  out  $clog2(DEPTH)+1  occupied entries
- committed_o  out  $clog2(DEPTH)+1  committed entries
- amo_cnt_o  out  CNT_W  issued-AMO count

Function
REQ-005 SHALL store entries {op, paddr, data, size} in a circular buffer with head, tail and commit pointers; wrap-around modulo DEPTH.
REQ-006 SHALL assert ready_o when usage_o < DEPTH, evaluated on registered state (a pop in the same cycle does not free a slot for a push).
REQ-007 SHALL write an entry at the tail and increment usage_o on the next edge when valid_i & ready_o; valid_i while full is dropped.
REQ-008 SHALL mark the oldest uncommitted entry committed on amo_commit_i; amo_commit_i with no uncommitted entry is ignored.
REQ-009 SHALL use a two-state FSM, IDLE and ISSUE; IDLE->ISSUE when the head is committed and no_st_pending_i=1; ISSUE->IDLE on amo_resp_i.ack.
REQ-010 SHALL drive amo_req_o.req=1 exactly in ISSUE, holding the head fields stable until ack, independent of no_st_pending_i and flush_i.
REQ-011 SHALL drive amo_req_o.operand_a as paddr zero-extended to 64 bits and operand_b as data zero-extended to 64 bits; amo_op and size from the head.
REQ-012 SHALL, on ack in ISSUE, pop the head and decrement usage_o and committed_o on the next edge; ack in IDLE is ignored.
REQ-013 SHALL allow a new issue no earlier than the cycle after an ack (one idle cycle between requests).
REQ-014 SHALL, on flush_i, discard all uncommitted entries (tail := commit pointer) and retain committed entries and an in-flight request.
REQ-015 SHALL, for simultaneous events, apply commit before flush (the entry committed that cycle survives), drop a push coinciding with flush, and allow pop together with push or flush.
REQ-016 SHALL keep committed_o <= usage_o at all times.

Reset
REQ-017 SHALL, when rst_ni=0 at a clock edge, clear all pointers and counters, enter IDLE, and give usage_o=0, committed_o=0, ready_o=1, amo_req_o.req=0, amo_cnt_o=0; entry payloads need not be reset.
REQ-018 SHALL treat clr_i=1 identically to reset except amo_cnt_o is retained; reset or clear mid-request drops req the following cycle without awaiting ack.

Configuration
REQ-019 SHALL, with macro AMO_QUEUE_STATS_EN defined, increment amo_cnt_o on each IDLE->ISSUE transition, saturating at 2^CNT_W-1; without it amo_cnt_o is constant 0 and no counter flops exist.

Verification
REQ-020 Push 4 AMOs (DEPTH=4), no commit -> ready_o=0, usage_o=4, req=0; a fifth valid_i is dropped.
REQ-021 Push A,B; commit once; no_st_pending_i=1 -> req=1 with A's paddr next cycle; ack after 3 cycles -> usage_o=1, req=0 for at least one cycle.
REQ-022 Push A,B,C; commit A; flush_i with amo_commit_i same cycle -> usage_o=2, committed_o=2, B retained, C gone.
REQ-023 In ISSUE, drop no_st_pending_i and pulse flush_i -> req stays 1, fields unchanged until ack.
REQ-024 rst_ni=0 while req=1 with 3 entries -> next cycle req=0, usage_o=0, ready_o=1; late ack ignored.
REQ-025 With AMO_QUEUE_STATS_EN and CNT_W=2, issue 5 AMOs -> amo_cnt_o=3; without the macro -> amo_cnt_o=0.
